// File: rtl/i2c_trx.sv
// I2C target with an 8 x 8-bit register file behind a register pointer.
// SCL/SDA are oversampled on clk_50M; SDA is driven open-drain, SCL is never driven.
`timescale 1ns/1ps
module i2c_trx #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NREG        = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic clk_50M,
    input  logic rst_n,
    inout  wire  Pad_SDA,
    inout  wire  Pad_SCL
);

    typedef enum logic [3:0] {
        IDLE, DEV_ADDR, ADDR_ACK, REG_PTR, PTR_ACK,
        WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t                 state;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic [7:0]             ptr;
    logic                   rw;
    logic                   sda_low;
    logic [7:0]             regs [NREG];
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;

    logic       scl_s;
    logic       sda_s;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [7:0] cur_reg;

    assign Pad_SDA = sda_low ? 1'b0 : 1'bz;
    assign Pad_SCL = 1'bz;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // Bus conditions only count while SCL has been high for both samples.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign cur_reg   = regs[ptr[2:0]];

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= {SYNC_STAGES{1'b1}};
            sda_sync <= {SYNC_STAGES{1'b1}};
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
            state    <= IDLE;
            bit_cnt  <= 4'd0;
            shift    <= 8'h00;
            ptr      <= 8'h00;
            rw       <= 1'b0;
            sda_low  <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], Pad_SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], Pad_SDA};
            scl_d    <= scl_s;
            sda_d    <= sda_s;

            if (start_det) begin
                state   <= DEV_ADDR;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
            end else if (stop_det) begin
                state   <= IDLE;
                bit_cnt <= 4'd0;
                sda_low <= 1'b0;
            end else begin
                case (state)
                    DEV_ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shift[7:1] == SLAVE_ADDR) begin
                                rw      <= shift[0];
                                sda_low <= 1'b1;
                                state   <= ADDR_ACK;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw) begin
                                // The falling edge that ends the ACK also presents data bit 7.
                                shift   <= cur_reg;
                                sda_low <= ~cur_reg[7];
                                bit_cnt <= 4'd1;
                                state   <= RD_DATA;
                            end else begin
                                sda_low <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= REG_PTR;
                            end
                        end
                    end
                    REG_PTR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr     <= shift;
                            bit_cnt <= 4'd0;
                            sda_low <= 1'b1;
                            state   <= PTR_ACK;
                        end
                    end
                    PTR_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            sda_low <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= WR_DATA;
                        end
                    end
                    WR_DATA: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            regs[ptr[2:0]] <= shift;
                            ptr            <= ptr + 8'd1;
                            bit_cnt        <= 4'd0;
                            sda_low        <= 1'b1;
                            state          <= WR_ACK;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt == 4'd0) begin
                                shift   <= cur_reg;
                                sda_low <= ~cur_reg[7];
                                bit_cnt <= 4'd1;
                            end else if (bit_cnt == 4'd8) begin
                                sda_low <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RD_ACK;
                            end else begin
                                sda_low <= ~shift[6];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            ptr     <= ptr + 8'd1;
                            bit_cnt <= 4'd0;
                            state   <= sda_s ? WAIT_STOP : RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_trx.sv
// Directed bench for i2c_trx: a bit-banged I2C master on pulled-up open-drain lines.
`timescale 1ns/1ps
module tb_i2c_trx;

    localparam int         Q   = 150;
    localparam logic [7:0] A_W = 8'hA0;
    localparam logic [7:0] A_R = 8'hA1;

    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    logic m_scl_low = 1'b0;
    logic m_sda_low = 1'b0;
    wire  sda;
    wire  scl;
    int   n_vec = 0;
    int   n_err = 0;

    pullup (sda);
    pullup (scl);
    assign sda = m_sda_low ? 1'b0 : 1'bz;
    assign scl = m_scl_low ? 1'b0 : 1'bz;

    i2c_trx dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .Pad_SDA (sda),
        .Pad_SCL (scl)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic bus_start();
        if (m_scl_low) begin
            m_sda_low = 1'b0; #(Q);
            m_scl_low = 1'b0; #(Q);
        end
        m_sda_low = 1'b1; #(Q);
        m_scl_low = 1'b1; #(Q);
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #(Q);
        m_scl_low = 1'b0; #(Q);
        m_sda_low = 1'b0; #(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda_low = ~b;   #(Q);
        m_scl_low = 1'b0; #(2*Q);
        m_scl_low = 1'b1; #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda_low = 1'b0; #(Q);
        m_scl_low = 1'b0; #(Q);
        b = sda;          #(Q);
        m_scl_low = 1'b1; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic read_reg(input logic [7:0] p, output logic [7:0] d, output logic [2:0] acks);
        bus_start();
        write_byte(A_W, acks[2]);
        write_byte(p, acks[1]);
        bus_start();
        write_byte(A_R, acks[0]);
        read_byte(d, 1'b1);
        bus_stop();
    endtask

    task automatic write_reg(input logic [7:0] p, input logic [7:0] d, output logic [2:0] acks);
        bus_start();
        write_byte(A_W, acks[2]);
        write_byte(p, acks[1]);
        write_byte(d, acks[0]);
        bus_stop();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic [2:0] acks;
        rst_n = 1'b0;
        #(100);
        n_vec++;
        if (sda !== 1'b1) begin
            n_err++; $display("FAIL reset_sda: got %b expected 1", sda);
        end
        rst_n = 1'b1;
        #(200);
        n_vec++;
        if (dut.state !== 4'd0) begin
            n_err++; $display("FAIL reset_state: got %0d expected 0", dut.state);
        end
        for (int n = 0; n < 8; n++) begin
            read_reg(8'(n), d, acks);
            n_vec++;
            if (acks !== 3'b000) begin
                n_err++; $display("FAIL reset_acks[%0d]: got %b expected 000", n, acks);
            end
            n_vec++;
            if (d !== 8'h00) begin
                n_err++; $display("FAIL reset_read[%0d]: got %h expected 00", n, d);
            end
        end
    endtask

    task automatic test_write_read(input logic [7:0] base);
        logic [7:0] d;
        logic [2:0] acks;
        for (int n = 0; n < 8; n++) begin
            write_reg(8'(n), base + 8'(n), acks);
            n_vec++;
            if (acks !== 3'b000) begin
                n_err++; $display("FAIL write_acks[%0d]: got %b expected 000", n, acks);
            end
        end
        for (int n = 0; n < 8; n++) begin
            read_reg(8'(n), d, acks);
            n_vec++;
            if (acks !== 3'b000) begin
                n_err++; $display("FAIL read_acks[%0d]: got %b expected 000", n, acks);
            end
            n_vec++;
            if (d !== base + 8'(n)) begin
                n_err++; $display("FAIL read_back[%0d]: got %h expected %h", n, d, base + 8'(n));
            end
        end
    endtask

    task automatic test_bad_addr();
        logic       a0;
        logic       a1;
        logic       a2;
        logic [7:0] d;
        logic [2:0] acks;
        bus_start();
        write_byte(8'hA2, a0);
        write_byte(8'h03, a1);
        write_byte(8'hFF, a2);
        bus_stop();
        n_vec++;
        if (a0 !== 1'b1) begin
            n_err++; $display("FAIL bad_addr_ack: got %b expected 1", a0);
        end
        n_vec++;
        if ({a1, a2} !== 2'b11) begin
            n_err++; $display("FAIL bad_addr_data_ack: got %b expected 11", {a1, a2});
        end
        read_reg(8'h03, d, acks);
        n_vec++;
        if (d !== 8'h0B) begin
            n_err++; $display("FAIL bad_addr_reg3: got %h expected 0b", d);
        end
    endtask

    task automatic test_start_stop();
        logic [7:0] d;
        logic [2:0] acks;
        for (int k = 0; k < 2; k++) begin
            bus_start();
            bus_stop();
        end
        #(200);
        n_vec++;
        if (dut.state !== 4'd0) begin
            n_err++; $display("FAIL start_stop_state: got %0d expected 0", dut.state);
        end
        n_vec++;
        if (sda !== 1'b1) begin
            n_err++; $display("FAIL start_stop_sda: got %b expected 1", sda);
        end
        read_reg(8'h03, d, acks);
        n_vec++;
        if (d !== 8'h0B) begin
            n_err++; $display("FAIL start_stop_reg3: got %h expected 0b", d);
        end
    endtask

    task automatic test_stop_mid_byte();
        logic       a;
        logic [7:0] d;
        logic [2:0] acks;
        bus_start();
        write_byte(A_W, a);
        write_byte(8'h05, a);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop();
        read_reg(8'h05, d, acks);
        n_vec++;
        if (d !== 8'h0D) begin
            n_err++; $display("FAIL stop_mid_byte_reg5: got %h expected 0d", d);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] acks4;
        logic [7:0] d;
        logic [2:0] acks;
        bus_start();
        write_byte(A_W, acks4[3]);
        write_byte(8'h07, acks4[2]);
        write_byte(8'hAA, acks4[1]);
        write_byte(8'h55, acks4[0]);
        bus_stop();
        n_vec++;
        if (acks4 !== 4'b0000) begin
            n_err++; $display("FAIL wrap_acks: got %b expected 0000", acks4);
        end
        read_reg(8'h07, d, acks);
        n_vec++;
        if (d !== 8'hAA) begin
            n_err++; $display("FAIL wrap_reg7: got %h expected aa", d);
        end
        read_reg(8'h00, d, acks);
        n_vec++;
        if (d !== 8'h55) begin
            n_err++; $display("FAIL wrap_reg0: got %h expected 55", d);
        end
    endtask

    task automatic test_back_to_back();
        logic       a;
        logic [7:0] d0;
        logic [7:0] d1;
        bus_start();
        write_byte(A_W, a);
        write_byte(8'h07, a);
        bus_start();
        write_byte(A_R, a);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        bus_stop();
        n_vec++;
        if (d0 !== 8'hAA) begin
            n_err++; $display("FAIL seq_read_first: got %h expected aa", d0);
        end
        n_vec++;
        if (d1 !== 8'h55) begin
            n_err++; $display("FAIL seq_read_wrap: got %h expected 55", d1);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] a;
        logic [7:0] d;
        logic [2:0] acks;
        a = A_W;
        bus_start();
        for (int i = 7; i >= 0; i--) write_bit(a[i]);
        m_sda_low = 1'b0;
        #(Q);
        n_vec++;
        if (sda !== 1'b0) begin
            n_err++; $display("FAIL mid_ack_low: got %b expected 0", sda);
        end
        rst_n = 1'b0;
        #(1);
        n_vec++;
        if (sda !== 1'b1) begin
            n_err++; $display("FAIL mid_reset_release: got %b expected 1", sda);
        end
        #(Q);
        rst_n = 1'b1;
        #(Q);
        m_scl_low = 1'b0;
        #(Q);
        read_reg(8'h07, d, acks);
        n_vec++;
        if (d !== 8'h00) begin
            n_err++; $display("FAIL mid_reset_reg7: got %h expected 00", d);
        end
    endtask

    initial begin
        test_reset();
        test_write_read(8'h00);
        test_write_read(8'h08);
        test_bad_addr();
        test_start_stop();
        test_stop_mid_byte();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
